// File: rtl/misaligned_mem_access.sv
// rtl/misaligned_mem_access.sv - load/store unit splitting misaligned accesses into word-aligned beats
module misaligned_mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, FIN} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic [31:0] word0_q, word0_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic        mem_wr_en_q, mem_wr_en_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // In IDLE the beat math looks at the live request so ACC1 outputs can be registered on acceptance.
    logic        cur_write;
    logic [2:0]  cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  n_mask;
    logic [7:0]  lane_mask;
    logic [63:0] wdata_shift;
    logic        cur_split;
    logic        cur_legal;
    logic [63:0] read_pair;
    logic [31:0] read_word;
    logic [31:0] load_result;

    always_comb begin
        cur_write = (state_q == IDLE) ? req_write : write_q;
        cur_size  = (state_q == IDLE) ? req_size  : size_q;
        cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

        case (cur_size[1:0])
            2'b00:   n_mask = 4'b0001;
            2'b01:   n_mask = 4'b0011;
            default: n_mask = 4'b1111;
        endcase

        case (cur_size)
            3'b000, 3'b001, 3'b010: cur_legal = 1'b1;
            3'b100, 3'b101:         cur_legal = ~cur_write;
            default:                cur_legal = 1'b0;
        endcase

        // Upper nibble / word of the shifted lane mask and data belong to the second beat.
        lane_mask   = {4'b0000, n_mask} << cur_addr[1:0];
        wdata_shift = {32'h0, cur_wdata} << {cur_addr[1:0], 3'b000};
        cur_split   = (lane_mask[7:4] != 4'b0000);
    end

    always_comb begin
        read_pair = split_q ? {mem_rdata, word0_q} : {32'h0, mem_rdata};
        read_word = 32'(read_pair >> {addr_q[1:0], 3'b000});
        case (size_q)
            3'b000:  load_result = {{24{read_word[7]}}, read_word[7:0]};
            3'b001:  load_result = {{16{read_word[15]}}, read_word[15:0]};
            3'b100:  load_result = {24'h0, read_word[7:0]};
            3'b101:  load_result = {16'h0, read_word[15:0]};
            default: load_result = read_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        word0_d     = word0_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_wstrb_d = 4'b0000;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    split_d = cur_split;
                    if (cur_legal) begin
                        state_d     = ACC1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_rd_en_d = ~req_write;
                        mem_wr_en_d = req_write;
                        mem_wstrb_d = req_write ? lane_mask[3:0] : 4'b0000;
                        if (req_write) begin
                            mem_wdata_d = wdata_shift[31:0];
                        end
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ACC1: begin
                if (split_q) begin
                    state_d     = ACC2;
                    mem_addr_d  = mem_addr_q + 32'd4;
                    mem_rd_en_d = ~write_q;
                    mem_wr_en_d = write_q;
                    mem_wstrb_d = write_q ? lane_mask[7:4] : 4'b0000;
                    if (write_q) begin
                        mem_wdata_d = wdata_shift[63:32];
                    end
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            ACC2: begin
                word0_d = mem_rdata;
                state_d = FIN;
                done_d  = 1'b1;
            end
            default: begin
                if (!write_q && !err_q) begin
                    rdata_d = load_result;
                end
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            size_q      <= 3'b000;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            split_q     <= 1'b0;
            word0_q     <= 32'h0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            word0_q     <= word0_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_misaligned_mem_access.sv
// tb/tb_misaligned_mem_access.sv - scoreboard bench for misaligned_mem_access
module tb_misaligned_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [3:0]  mem_wstrb;

    misaligned_mem_access dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory indexed by addr[11:2]; read data appears the cycle after mem_rd_en.
    logic [31:0] mem [0:1023];
    logic [31:0] mem_rdata_r = 32'h0;
    assign mem_rdata = mem_rdata_r;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata_r <= mem[mem_addr[11:2]];
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic        err;
        int          lat;
        logic [31:0] rdata;
        int          t0;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } mexp_t;

    exp_t  sb_q[$];
    mexp_t mem_q[$];
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata);
        mexp_t m;
        m.wr = wr; m.addr = addr; m.strb = strb; m.wdata = wdata;
        mem_q.push_back(m);
    endtask

    // Monitor: compares completions and memory beats against queued expectations.
    logic        rd_pending = 1'b0;
    logic [31:0] rd_exp = 32'h0;
    always @(negedge clk) begin
        exp_t  e;
        mexp_t m;
        if (rd_pending) begin
            chk("rdata", rdata, rd_exp);
            rd_pending = 1'b0;
        end
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_done: got done with empty scoreboard");
            end else begin
                e = sb_q.pop_front();
                chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
                chk("err", {31'h0, err}, {31'h0, e.err});
                rd_exp = e.rdata;
                rd_pending = 1'b1;
            end
        end
        if (rst_n && (mem_rd_en || mem_wr_en)) begin
            if (mem_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL spurious_mem: addr 0x%08h rd %0b wr %0b", mem_addr, mem_rd_en, mem_wr_en);
            end else begin
                m = mem_q.pop_front();
                chk("mem_addr", mem_addr, m.addr);
                chk("mem_rd_wr", {30'h0, mem_wr_en, mem_rd_en}, {30'h0, m.wr, ~m.wr});
                chk("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, m.strb});
                if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic hold, input logic e_err,
                         input int e_lat, input logic [31:0] e_rd);
        exp_t e;
        logic got;
        @(negedge clk);
        req_write = w; req_size = size; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!w && !e_err) last_rd = e_rd;
        e.err = e_err; e.lat = e_lat; e.rdata = last_rd; e.t0 = cyc;
        sb_q.push_back(e);
        if (!hold) req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        if (!got) begin
            tests++; fails++;
            $display("FAIL timeout: no done for addr 0x%08h", addr);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_err"}, {31'h0, err}, 32'h0);
        chk({tag, "_rdata"}, rdata, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_ctl"}, {26'h0, mem_wstrb, mem_rd_en, mem_wr_en}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h040] = 32'h44332211;
        mem[10'h041] = 32'h88776655;
        mem[10'h3FF] = 32'hA1B2C3D4;
        mem[10'h000] = 32'hE5F60708;

        #3;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h100, 32'h0, 0, 0, 2, 32'h44332211);
        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h102, 32'h0, 0, 0, 3, 32'h66554433);
        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b001, 32'h103, 32'h0, 0, 0, 3, 32'h00005544);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b000, 32'h107, 32'h0, 0, 0, 2, 32'hFFFFFF88);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b100, 32'h107, 32'h0, 0, 0, 2, 32'h00000088);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b101, 32'h106, 32'h0, 0, 0, 2, 32'h00008877);

        issue(0, 3'b011, 32'h100, 32'h0, 0, 1, 1, 32'h0);
        issue(1, 3'b100, 32'h100, 32'h12345678, 0, 1, 1, 32'h0);

        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h100, 32'h0, 1, 0, 2, 32'h44332211);

        exp_mem(0, 32'hFFFFFFFC, 4'b0000, 32'h0);
        exp_mem(0, 32'h00000000, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 0, 3, 32'h0708A1B2);

        // Split load aborted by reset while its second beat is on the bus.
        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        @(negedge clk);
        req_write = 1'b0; req_size = 3'b010; req_addr = 32'h102; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        last_rd = 32'h0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h104, 32'h0, 0, 0, 2, 32'h88776655);

        exp_mem(1, 32'h100, 4'b1110, 32'hBBCCDD00);
        exp_mem(1, 32'h104, 4'b0001, 32'h000000AA);
        issue(1, 3'b010, 32'h101, 32'hAABBCCDD, 0, 0, 3, 32'h0);
        exp_mem(1, 32'h104, 4'b0100, 32'h565A0000);
        issue(1, 3'b000, 32'h106, 32'h1234565A, 0, 0, 2, 32'h0);
        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h100, 32'h0, 0, 0, 2, 32'hBBCCDD11);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h104, 32'h0, 0, 0, 2, 32'h885A66AA);
        exp_mem(1, 32'h100, 4'b1000, 32'hEF000000);
        exp_mem(1, 32'h104, 4'b0001, 32'h000000BE);
        issue(1, 3'b001, 32'h103, 32'h0000BEEF, 0, 0, 3, 32'h0);
        exp_mem(0, 32'h100, 4'b0000, 32'h0);
        exp_mem(0, 32'h104, 4'b0000, 32'h0);
        issue(0, 3'b010, 32'h102, 32'h0, 0, 0, 3, 32'h66BEEFCC);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("mem_drained", 32'(mem_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
